// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions,
// and width-generic constant helpers used by the FP datapath blocks.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] opA_i;
  logic [W-1:0] opB_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] MUL_o;
  logic [3:0]   flags_o;

  modport master (
    output in_valid_i, opA_i, opB_i, out_ready_i,
    input  in_ready_o, out_valid_o, MUL_o, flags_o
  );

  modport slave (
    input  in_valid_i, opA_i, opB_i, out_ready_i,
    output in_ready_o, out_valid_o, MUL_o, flags_o
  );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even, exception priority and result packing.
// Takes a normalised significand (hidden bit stripped) and an unbiased-range exponent.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     sign_i,
  input  fp_class_t                cls_a_i,
  input  fp_class_t                cls_b_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W:0]         sig_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [3:0]               flags_o
);

  localparam logic [63:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [EXP_W+MAN_W:0] QNAN      = QNAN_FULL[EXP_W+MAN_W:0];

  function automatic logic [MAN_W:0] rne(input logic [MAN_W-1:0] frac,
                                         input logic guard,
                                         input logic sticky);
    return {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
  endfunction

  // Returns {overflow, underflow} for the post-rounding exponent.
  function automatic logic [1:0] exp_range(input logic signed [EXP_W+1:0] e);
    logic ovf;
    logic unf;
    ovf = (e >= $signed({2'b00, {EXP_W{1'b1}}}));
    unf = (e <= $signed({(EXP_W+2){1'b0}}));
    return {ovf, unf};
  endfunction

  logic [MAN_W-1:0]        frac_t;
  logic                    guard;
  logic                    sticky;
  logic [MAN_W:0]          rnd;
  logic                    carry;
  logic signed [EXP_W+1:0] exp_r;
  logic [MAN_W-1:0]        frac_r;
  logic                    ovf;
  logic                    unf;
  logic                    is_nan;
  logic                    is_inf;
  logic                    is_zero;

  always_comb begin
    frac_t   = sig_i[2*MAN_W:MAN_W+1];
    guard    = sig_i[MAN_W];
    sticky   = |sig_i[MAN_W-1:0];
    rnd      = rne(frac_t, guard, sticky);
    carry    = rnd[MAN_W];
    exp_r    = exp_i + $signed({{(EXP_W+1){1'b0}}, carry});
    frac_r   = carry ? '0 : rnd[MAN_W-1:0];
    {ovf, unf} = exp_range(exp_r);

    is_nan  = (cls_a_i == FP_NAN) || (cls_b_i == FP_NAN) ||
              ((cls_a_i == FP_INF) && (cls_b_i == FP_ZERO)) ||
              ((cls_a_i == FP_ZERO) && (cls_b_i == FP_INF));
    is_inf  = (cls_a_i == FP_INF) || (cls_b_i == FP_INF);
    is_zero = (cls_a_i == FP_ZERO) || (cls_b_i == FP_ZERO);

    result_o = '0;
    flags_o  = '0;
    if (is_nan) begin
      result_o         = QNAN;
      flags_o[FLG_INV] = 1'b1;
    end else if (is_inf) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (is_zero) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
    end else if (ovf) begin
      result_o         = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLG_OVF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else if (unf) begin
      result_o         = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UNF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else begin
      result_o         = {sign_i, exp_r[EXP_W-1:0], frac_r};
      flags_o[FLG_INX] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined binary FP multiplier with a global-stall valid/ready
// handshake: S1 unpack/classify/multiply, S2 normalise, S3 round/pack.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fp_mul_pipe_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic signed [EW-1:0] BIAS_S = BIAS[EW-1:0];
  localparam logic signed [EW-1:0] ONE_S  = {{(EW-1){1'b0}}, 1'b1};

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0) return FP_ZERO;
    if (&e)      return (f == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic advance;
  assign advance       = !bus.out_valid_o || bus.out_ready_i;
  assign bus.in_ready_o = advance;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  assign {sign_a, exp_a, frac_a} = bus.opA_i;
  assign {sign_b, exp_b, frac_b} = bus.opB_i;

  logic [PW-1:0]         prod_s1;
  logic signed [EW-1:0]  exp_s1;
  assign prod_s1 = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
  assign exp_s1  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

  // ---- S1 -> S2 boundary: classified operands and raw significand product
  logic                 vld_p0;
  logic                 sign_p0;
  fp_class_t            cls_a_p0, cls_b_p0;
  logic signed [EW-1:0] exp_p0;
  logic [PW-1:0]        prod_p0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= bus.in_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      sign_p0  <= sign_a ^ sign_b;
      cls_a_p0 <= classify(exp_a, frac_a);
      cls_b_p0 <= classify(exp_b, frac_b);
      exp_p0   <= exp_s1;
      prod_p0  <= prod_s1;
    end
  end

  // Product lies in [1,4): either take the top bit as the hidden one and bump
  // the exponent, or shift left so the hidden one lands in the same place.
  logic [PW-2:0]        sig_s2;
  logic signed [EW-1:0] exp_s2;
  always_comb begin
    if (prod_p0[PW-1]) begin
      sig_s2 = prod_p0[PW-2:0];
      exp_s2 = exp_p0 + ONE_S;
    end else begin
      sig_s2 = {prod_p0[PW-3:0], 1'b0};
      exp_s2 = exp_p0;
    end
  end

  // ---- S2 -> S3 boundary: normalised significand without hidden bit
  logic                 vld_p1;
  logic                 sign_p1;
  fp_class_t            cls_a_p1, cls_b_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-2:0]        sig_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      sign_p1  <= sign_p0;
      cls_a_p1 <= cls_a_p0;
      cls_b_p1 <= cls_b_p0;
      exp_p1   <= exp_s2;
      sig_p1   <= sig_s2;
    end
  end

  logic [W-1:0] res_s3;
  logic [3:0]   flg_s3;

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign_i   (sign_p1),
    .cls_a_i  (cls_a_p1),
    .cls_b_i  (cls_b_p1),
    .exp_i    (exp_p1),
    .sig_i    (sig_p1),
    .result_o (res_s3),
    .flags_o  (flg_s3)
  );

  // ---- S3 output register: result and flags are cleared on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.out_valid_o <= 1'b0;
      bus.MUL_o       <= '0;
      bus.flags_o     <= '0;
    end else if (advance) begin
      bus.out_valid_o <= vld_p1;
      bus.MUL_o       <= res_s3;
      bus.flags_o     <= flg_s3;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: FP16 vectors, stall stream, mid-stream reset,
// and an FP32 instance sharing the same clock and reset.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();
  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));
  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on either instance, checking latency, result and flags.
  task automatic run_op(input bit wide, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl);
    int lat;
    if (wide) begin
      bus32.in_valid_i = 1'b1; bus32.opA_i = a; bus32.opB_i = b;
    end else begin
      bus16.in_valid_i = 1'b1; bus16.opA_i = a[15:0]; bus16.opB_i = b[15:0];
    end
    step();
    bus16.in_valid_i = 1'b0;
    bus32.in_valid_i = 1'b0;
    lat = 1;
    while ((wide ? bus32.out_valid_o : bus16.out_valid_o) !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd3);
    if (wide) begin
      check({tag, " result"}, 64'(bus32.MUL_o), 64'(res));
      check({tag, " flags"}, 64'(bus32.flags_o), 64'(fl));
    end else begin
      check({tag, " result"}, 64'(bus16.MUL_o), 64'(res[15:0]));
      check({tag, " flags"}, 64'(bus16.flags_o), 64'(fl));
    end
    step();
  endtask

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic [15:0] sr [8];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int oidx;
    int seen;
    logic acc;
    logic emit;

    sa = '{16'h3C00, 16'h4000, 16'h4200, 16'h4200, 16'h4400, 16'hBC00, 16'h3800, 16'h4500};
    sb = '{16'h4000, 16'h4000, 16'h4000, 16'h4200, 16'h4200, 16'h4400, 16'h3800, 16'h4000};
    sr = '{16'h4000, 16'h4400, 16'h4600, 16'h4880, 16'h4A00, 16'hC400, 16'h3400, 16'h4900};

    rst = 1'b1;
    bus16.in_valid_i = 1'b0; bus16.opA_i = '0; bus16.opB_i = '0; bus16.out_ready_i = 1'b1;
    bus32.in_valid_i = 1'b0; bus32.opA_i = '0; bus32.opB_i = '0; bus32.out_ready_i = 1'b1;
    #12;
    check("reset out_valid", 64'(bus16.out_valid_o), 64'd0);
    check("reset MUL", 64'(bus16.MUL_o), 64'd0);
    check("reset flags", 64'(bus16.flags_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("idle in_ready", 64'(bus16.in_ready_o), 64'd1);

    run_op(1'b0, "1.5x2",       32'h3E00, 32'h4000, 32'h4200, 4'b0000);
    run_op(1'b0, "-2x2",        32'hC000, 32'h4000, 32'hC400, 4'b0000);
    run_op(1'b0, "rne down",    32'h3C01, 32'h3C01, 32'h3C02, 4'b0001);
    run_op(1'b0, "overflow",    32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0101);
    run_op(1'b0, "underflow",   32'h0400, 32'h0400, 32'h0000, 4'b0011);
    run_op(1'b0, "inf x zero",  32'h7C00, 32'h0000, 32'h7E00, 4'b1000);
    run_op(1'b0, "nan x one",   32'h7E01, 32'h3C00, 32'h7E00, 4'b1000);
    run_op(1'b0, "-inf x 2",    32'hFC00, 32'h4000, 32'hFC00, 4'b0000);

    // Back-to-back stream with the consumer stalling on cycles 4..6.
    idx  = 0;
    oidx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus16.out_ready_i = !(cyc >= 4 && cyc <= 6);
      if (idx < 8) begin
        bus16.in_valid_i = 1'b1; bus16.opA_i = sa[idx]; bus16.opB_i = sb[idx];
      end else begin
        bus16.in_valid_i = 1'b0;
      end
      #1;
      acc  = bus16.in_valid_i & bus16.in_ready_o;
      emit = bus16.out_valid_o & bus16.out_ready_i;
      if (!bus16.out_ready_i && bus16.out_valid_o)
        check($sformatf("stream stall in_ready c%0d", cyc), 64'(bus16.in_ready_o), 64'd0);
      if (emit) begin
        if (oidx < 8) begin
          check($sformatf("stream result %0d", oidx), 64'(bus16.MUL_o), 64'(sr[oidx]));
          check($sformatf("stream flags %0d", oidx), 64'(bus16.flags_o), 64'd0);
        end
        oidx++;
      end
      step();
      if (acc) idx++;
    end
    check("stream accepted", 64'(idx), 64'd8);
    check("stream emitted", 64'(oidx), 64'd8);
    bus16.out_ready_i = 1'b1;

    // Reset with one result presented and two operations in flight.
    for (int k = 0; k < 3; k++) begin
      bus16.in_valid_i = 1'b1; bus16.opA_i = sa[k]; bus16.opB_i = sb[k];
      step();
    end
    bus16.in_valid_i = 1'b0;
    check("pre-reset out_valid", 64'(bus16.out_valid_o), 64'd1);
    rst = 1'b1;
    #1;
    check("async reset out_valid", 64'(bus16.out_valid_o), 64'd0);
    check("async reset MUL", 64'(bus16.MUL_o), 64'd0);
    check("async reset flags", 64'(bus16.flags_o), 64'd0);
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus16.out_valid_o === 1'b1) seen++;
    end
    check("no stale result after reset", 64'(seen), 64'd0);

    run_op(1'b0, "post-reset 1.5x2", 32'h3E00, 32'h4000, 32'h4200, 4'b0000);
    run_op(1'b1, "fp32 1.5x2",       32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op(1'b1, "fp32 inf x zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style binary floating-point multiplier; FP16 by default, any exponent/mantissa width by parameter.
- Accepts one operand pair per cycle over a valid/ready handshake and returns a correctly rounded product three cycles later.
- Rounding is round-to-nearest-even, and special values and exception flags are handled.
- Sits in the arithmetic datapath beside the FP adder and feeds the result bus.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored fraction width; significand = MAN_W+1 bits with the hidden 1.
- W, 1+EXP_W+MAN_W, total operand width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands this cycle.
- opA_i  in  W  operand A {sign, exp, frac}.
- opB_i  in  W  operand B.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- MUL_o  out  W  product.
- flags_o  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid_o.

Behaviour:
- Reset (async, rst_i=1):
  - out_valid_o=0, MUL_o=0, flags_o=0.
  - All internal stage-valid bits clear.
  - In-flight operations are discarded, never emitted.
- Pipeline: S1 unpack/classify/multiply, S2 normalise, S3 round/pack/exceptions. Result registered at S3 output.
  - Latency = 3 cycles from accepted input to out_valid_o when unstalled.
  - Throughput = 1 per cycle.
- Handshake:
  - Transfer in when in_valid_i & in_ready_o.
  - Transfer out when out_valid_o & out_ready_i.
  - Global stall: advance = !out_valid_o | out_ready_i; in_ready_o = advance.
  - While stalled, all stage registers and MUL_o/flags_o hold.
  - Bubbles propagate as cleared valid bits.
- Classification per operand:
  - exp=0 → ZERO (subnormals flushed to signed zero, no flag).
  - exp=all-ones, frac=0 → INF.
  - exp=all-ones, frac≠0 → NAN.
  - Otherwise NORM.
- Sign = signA ^ signB for every non-NaN result.
- S1 arithmetic:
  - Significand product of two (MAN_W+1)-bit values gives 2*MAN_W+2 bits.
  - Exponent e = expA + expB - bias, in signed EXP_W+2 bits.
- S2 normalise: if product MSB set, shift right 1 and increment e. Product is always in [1,4), so no left shift is needed.
- S3 rounding (RNE):
  - Keep MAN_W fraction bits; guard = next bit, sticky = OR of the remaining bits.
  - Round up if guard & (sticky | lsb).
  - Carry out of the fraction increments e and zeroes the fraction.
  - inexact = guard | sticky.
- S3 exceptions, in priority order:
  1. Any NAN, or INF×ZERO → canonical qNaN {0, all-ones, 1 followed by zeros}; invalid=1, other flags 0.
  2. Any INF (other operand NORM or INF) → signed infinity, no flags.
  3. Any ZERO → signed zero, no flags.
  4. e ≥ 2^EXP_W-1 after rounding → signed infinity; overflow=1, inexact=1.
  5. e ≤ 0 → signed zero; underflow=1, inexact=1 (flush-to-zero, no subnormal output).
  6. Otherwise normal pack {sign, e[EXP_W-1:0], frac}.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate a result.

Decomposition:
- Package fp_pkg:
  - Class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - Flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0.
  - Bias function of EXP_W.
  - Canonical-qNaN constant function.
- One sub-module, fp_round_pack: combinational S3 logic (RNE, exception priority, pack). It will be shared with the FP adder successor.

Test Plan:
- 0x3E00×0x4000 (1.5×2.0) → 0x4200, flags 0, out_valid_o exactly 3 cycles after accept.
- 0xC000×0x4000 → 0xC400; 0x3C01×0x3C01 → 0x3C02 with inexact=1 (RNE rounds 1+2^-9+2^-20 down).
- 0x7BFF×0x7BFF → 0x7C00, flags 0b0101; 0x0400×0x0400 → 0x0000, flags 0b0011.
- 0x7C00×0x0000 → 0x7E00, flags 0b1000; 0x7E01×0x3C00 → 0x7E00 invalid; 0xFC00×0x4000 → 0xFC00, flags 0.
- Back-to-back stream of 8 pairs with out_ready_i low for cycles 4–6 → in_ready_o low during the stall, all 8 results in order, none lost or duplicated.
- Assert rst_i mid-stream with 2 ops in flight → out_valid_o drops immediately; no stale result after release. Repeat with EXP_W=8, MAN_W=23: 0x3FC00000×0x40000000 → 0x40400000.
